// File: rtl/sevenseg_serial_display.sv
// Four-digit seven-segment driver: binary value -> BCD -> segment/select frames,
// shifted out MSB first with a one-cycle latch strobe after every 16-bit frame.
module sevenseg_serial_display (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bin,
  output logic        seg_data,
  output logic        seg_latch
);

  localparam logic [4:0] LAST_K = 5'd16;

  logic [4:0]  k_reg, k_next;
  logic [1:0]  digit_reg, digit_next;
  logic [15:0] hold_reg, hold_next;
  logic [15:0] shift_reg, shift_next;
  logic        seg_data_reg, seg_data_next;
  logic        seg_latch_reg, seg_latch_next;

  logic [15:0] value;
  logic [15:0] bcd_work;
  logic [15:0] bin_work;
  logic [15:0] bcd;
  logic [7:0]  seg_bytes  [4];
  logic [7:0]  ctrl_bytes [4];
  logic [15:0] frame;

  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    logic [7:0] pat;
    case (code)
      4'd0:    pat = 8'hC0;
      4'd1:    pat = 8'hF9;
      4'd2:    pat = 8'hA4;
      4'd3:    pat = 8'hB0;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h92;
      4'd6:    pat = 8'h82;
      4'd7:    pat = 8'hF8;
      4'd8:    pat = 8'h80;
      4'd9:    pat = 8'h90;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  // A digit-0 frame captures bin on this very edge, so it must see bin directly.
  assign value = (digit_reg == 2'd0) ? bin : hold_reg;

  // Double-dabble limited to four BCD digits; the ten-thousands carry falls off the top.
  always_comb begin
    bcd_work = 16'd0;
    bin_work = value;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (bcd_work[4*j +: 4] >= 4'd5)
          bcd_work[4*j +: 4] = bcd_work[4*j +: 4] + 4'd3;
      end
      bcd_work = {bcd_work[14:0], bin_work[15]};
      bin_work = {bin_work[14:0], 1'b0};
    end
  end

  assign bcd = bcd_work;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] SEL = 4'b0001 << gi;
      assign seg_bytes[gi]  = seg_decode(bcd[4*gi +: 4]);
      assign ctrl_bytes[gi] = {4'hF, ~SEL};
    end
  endgenerate

  assign frame = {seg_bytes[digit_reg], ctrl_bytes[digit_reg]};

  always_comb begin
    k_next         = k_reg;
    digit_next     = digit_reg;
    hold_next      = hold_reg;
    shift_next     = shift_reg;
    seg_data_next  = 1'b0;
    seg_latch_next = 1'b0;
    if (k_reg == 5'd0) begin
      seg_data_next = frame[15];
      shift_next    = {frame[14:0], 1'b0};
      k_next        = 5'd1;
      if (digit_reg == 2'd0)
        hold_next = bin;
    end else if (k_reg == LAST_K) begin
      seg_latch_next = 1'b1;
      k_next         = 5'd0;
      digit_next     = digit_reg + 2'd1;
    end else begin
      seg_data_next = shift_reg[15];
      shift_next    = {shift_reg[14:0], 1'b0};
      k_next        = k_reg + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg         <= 5'd0;
      digit_reg     <= 2'd0;
      hold_reg      <= 16'd0;
      shift_reg     <= 16'd0;
      seg_data_reg  <= 1'b0;
      seg_latch_reg <= 1'b0;
    end else begin
      k_reg         <= k_next;
      digit_reg     <= digit_next;
      hold_reg      <= hold_next;
      shift_reg     <= shift_next;
      seg_data_reg  <= seg_data_next;
      seg_latch_reg <= seg_latch_next;
    end
  end

  assign seg_data  = seg_data_reg;
  assign seg_latch = seg_latch_reg;

endmodule

// File: tb/tb_sevenseg_serial_display.sv
// Randomized bench for sevenseg_serial_display against a decimal-arithmetic frame model.
module tb_sevenseg_serial_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bin;
  logic        seg_data;
  logic        seg_latch;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] seg_tbl [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  sevenseg_serial_display dut (
    .clk       (clk),
    .rst       (rst),
    .bin       (bin),
    .seg_data  (seg_data),
    .seg_latch (seg_latch)
  );

  // Expected frame for decimal digit d (0 = ones) of value v.
  function automatic logic [15:0] model_frame(input int v, input int d);
    int x;
    x = v % 10000;
    for (int i = 0; i < d; i++) x = x / 10;
    x = x % 10;
    return {seg_tbl[x], 8'hFF ^ (8'd1 << d)};
  endfunction

  // Collects one 17-clock frame; lat_ok is cleared if the strobe/data timing is wrong.
  task automatic get_frame(output logic [15:0] f, output bit lat_ok);
    lat_ok = 1'b1;
    f = 16'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      f[15-k] = seg_data;
      if (seg_latch !== 1'b0) lat_ok = 1'b0;
    end
    @(negedge clk);
    if (seg_latch !== 1'b1 || seg_data !== 1'b0) lat_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bin = 16'd1234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (seg_data !== 1'b0 || seg_latch !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state cycle=%0d got data=%b latch=%b need 0/0", c, seg_data, seg_latch);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_refresh(input int v, input string tag);
    logic [15:0] f;
    logic [15:0] exp_f;
    bit ok;
    bin = v[15:0];
    for (int d = 0; d < 4; d++) begin
      get_frame(f, ok);
      exp_f = model_frame(v, d);
      $display("%s bin=%0d digit=%0d frame=%h expect=%h", tag, v, d, f, exp_f);
      n_vec++;
      if (f !== exp_f) begin
        n_bad++;
        $display("FAIL %s_frame digit=%0d got=%h need=%h", tag, d, f, exp_f);
      end
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s_latch digit=%0d strobe/data timing got wrong need latch only at k=16 with data=0", tag, d);
      end
    end
  endtask

  task automatic test_random();
    int vals[$];
    vals = '{9999, 10000, 65535, 1, 10009};
    for (int i = 0; i < 10; i++) vals.push_back(int'($urandom_range(0, 65535)));
    foreach (vals[i]) test_refresh(vals[i], "random");
  endtask

  task automatic test_tearing(input int v1, input int v2);
    logic [15:0] f;
    logic [15:0] exp_f;
    bit ok;
    bin = v1[15:0];
    for (int d = 0; d < 4; d++) begin
      get_frame(f, ok);
      if (d == 0) bin = v2[15:0];
      exp_f = model_frame(v1, d);
      $display("tearing bin=%0d->%0d digit=%0d frame=%h expect=%h", v1, v2, d, f, exp_f);
      n_vec++;
      if (f !== exp_f || !ok) begin
        n_bad++;
        $display("FAIL tearing_frame digit=%0d got=%h ok=%b need=%h ok=1", d, f, ok, exp_f);
      end
    end
    for (int d = 0; d < 4; d++) begin
      get_frame(f, ok);
      exp_f = model_frame(v2, d);
      $display("tearing next bin=%0d digit=%0d frame=%h expect=%h", v2, d, f, exp_f);
      n_vec++;
      if (f !== exp_f || !ok) begin
        n_bad++;
        $display("FAIL tearing_next digit=%0d got=%h ok=%b need=%h ok=1", d, f, ok, exp_f);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] f;
    logic [15:0] exp_f;
    bit ok;
    int v;
    bin = 16'd4321;
    for (int d = 0; d < 2; d++) begin
      get_frame(f, ok);
      exp_f = model_frame(4321, d);
      n_vec++;
      if (f !== exp_f || !ok) begin
        n_bad++;
        $display("FAIL midreset_pre digit=%0d got=%h ok=%b need=%h ok=1", d, f, ok, exp_f);
      end
    end
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("midreset asserted at k=7 of hundreds frame data=%b latch=%b", seg_data, seg_latch);
    n_vec++;
    if (seg_data !== 1'b0 || seg_latch !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_out got data=%b latch=%b need 0/0", seg_data, seg_latch);
    end
    v = int'($urandom_range(0, 65535));
    bin = v[15:0];
    rst = 1'b0;
    test_refresh(v, "after_midreset");
  endtask

  task automatic test_reset_hold();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      $display("reset_hold cycle=%0d data=%b latch=%b", c, seg_data, seg_latch);
      n_vec++;
      if (seg_data !== 1'b0 || seg_latch !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold cycle=%0d got data=%b latch=%b need 0/0", c, seg_data, seg_latch);
      end
    end
    rst = 1'b0;
    test_refresh(2468, "after_hold");
  endtask

  initial begin
    rst = 1'b1;
    bin = 16'd0;
    test_reset();
    test_refresh(1234, "basic");
    test_refresh(0, "zero");
    test_refresh(65535, "max");
    test_refresh(9999, "nines");
    test_random();
    test_tearing(1234, 5678);
    test_tearing(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    test_mid_reset();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
